// File: rtl/fm_vin_timing_detect_if.sv
// Video input sync bundle and the measured timing results.
// The source drives syncs/DE; the detector returns timing.
interface fm_vin_timing_detect_if #(
    parameter int P_CNT_W = 12
) ();
    logic               i_hsync;
    logic               i_vsync;
    logic               i_de;
    logic [P_CNT_W-1:0] o_h_total;
    logic [P_CNT_W-1:0] o_h_active;
    logic [P_CNT_W-1:0] o_v_total;
    logic [P_CNT_W-1:0] o_v_active;
    logic               o_frame_start;
    logic               o_locked;

    modport master (
        output i_hsync, i_vsync, i_de,
        input  o_h_total, o_h_active,
        input  o_v_total, o_v_active,
        input  o_frame_start, o_locked
    );

    modport slave (
        input  i_hsync, i_vsync, i_de,
        output o_h_total, o_h_active,
        output o_v_total, o_v_active,
        output o_frame_start, o_locked
    );
endinterface

// File: rtl/fm_vin_timing_detect.sv
// Measures line/frame geometry of an incoming video stream
// and declares lock once consecutive frames agree.
module fm_vin_timing_detect #(
    parameter int P_CNT_W       = 12,
    parameter int P_LOCK_FRAMES = 2
) (
    input logic                   clk_sys,
    input logic                   rst_x,
    fm_vin_timing_detect_if.slave vin
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef logic [P_CNT_W-1:0]   cnt_t;
    typedef logic [4*P_CNT_W-1:0] tup_t;

    localparam cnt_t       CNT_MAX = '1;
    localparam logic [3:0] LOCK_N  = 4'(P_LOCK_FRAMES);

    function automatic cnt_t sat_inc(cnt_t v);
        return (v == CNT_MAX) ? v : v + cnt_t'(1);
    endfunction

    logic   hs1_q, vs1_q, de1_q, hs2_q, vs2_q;
    cnt_t   h_cnt_q, h_cnt_d;
    cnt_t   de_cnt_q, de_cnt_d;
    cnt_t   last_len_q, last_len_d;
    cnt_t   v_cnt_q, v_cnt_d;
    cnt_t   va_cnt_q, va_cnt_d;
    cnt_t   ha_max_q, ha_max_d;
    logic   sat_q, sat_d;
    state_e state_q, state_d;
    logic [3:0] m_q, m_d;
    tup_t   ref_q, ref_d;
    tup_t   out_q, out_d;
    logic   fs_q, fs_d;
    logic   lk_q, lk_d;

    logic       hs_rise, vs_rise;
    logic       frame_sat, match;
    logic [3:0] m_inc;
    tup_t       tuple;

    assign hs_rise = hs1_q & ~hs2_q;
    assign vs_rise = vs1_q & ~vs2_q;

    // Line-end update happens first so a coincident vsync
    // rise sees the line that just closed.
    always_comb begin
        h_cnt_d    = sat_inc(h_cnt_q);
        de_cnt_d   = de1_q ? sat_inc(de_cnt_q) : de_cnt_q;
        last_len_d = last_len_q;
        v_cnt_d    = v_cnt_q;
        va_cnt_d   = va_cnt_q;
        ha_max_d   = ha_max_q;
        if (hs_rise) begin
            h_cnt_d    = cnt_t'(1);
            de_cnt_d   = cnt_t'(de1_q);
            last_len_d = h_cnt_q;
            v_cnt_d    = sat_inc(v_cnt_q);
            if (de_cnt_q != '0)
                va_cnt_d = sat_inc(va_cnt_q);
            if (de_cnt_q > ha_max_q)
                ha_max_d = de_cnt_q;
        end
        sat_d = sat_q
              | (h_cnt_d == CNT_MAX)
              | (de_cnt_d == CNT_MAX)
              | (v_cnt_d == CNT_MAX)
              | (va_cnt_d == CNT_MAX);
        frame_sat = sat_d;
        tuple = {last_len_d, ha_max_d,
                 v_cnt_d, va_cnt_d};
        if (vs_rise) begin
            v_cnt_d  = '0;
            va_cnt_d = '0;
            ha_max_d = '0;
            sat_d    = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        ref_d   = ref_q;
        out_d   = out_q;
        fs_d    = 1'b0;
        m_inc   = m_q + 4'd1;
        match   = (tuple == ref_q) && !frame_sat;
        if (vs_rise) begin
            fs_d  = 1'b1;
            ref_d = tuple;
            unique case (state_q)
                SEARCH: begin
                    state_d = TRACK;
                    m_d     = '0;
                end
                TRACK: begin
                    out_d = tuple;
                    if (match) begin
                        m_d = m_inc;
                        if (m_inc >= LOCK_N)
                            state_d = LOCKED;
                    end else begin
                        m_d = '0;
                    end
                end
                LOCKED: begin
                    out_d = tuple;
                    if (!match) begin
                        state_d = TRACK;
                        m_d     = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    m_d     = '0;
                end
            endcase
        end else if (v_cnt_q == CNT_MAX) begin
            // No vsync for a whole line-counter range.
            state_d = SEARCH;
            m_d     = '0;
        end
        lk_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_sys) begin
        if (rst_x) begin
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            de1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            h_cnt_q    <= '0;
            de_cnt_q   <= '0;
            last_len_q <= '0;
            v_cnt_q    <= '0;
            va_cnt_q   <= '0;
            ha_max_q   <= '0;
            sat_q      <= 1'b0;
            state_q    <= SEARCH;
            m_q        <= '0;
            ref_q      <= '0;
            out_q      <= '0;
            fs_q       <= 1'b0;
            lk_q       <= 1'b0;
        end else begin
            hs1_q      <= vin.i_hsync;
            vs1_q      <= vin.i_vsync;
            de1_q      <= vin.i_de;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            h_cnt_q    <= h_cnt_d;
            de_cnt_q   <= de_cnt_d;
            last_len_q <= last_len_d;
            v_cnt_q    <= v_cnt_d;
            va_cnt_q   <= va_cnt_d;
            ha_max_q   <= ha_max_d;
            sat_q      <= sat_d;
            state_q    <= state_d;
            m_q        <= m_d;
            ref_q      <= ref_d;
            out_q      <= out_d;
            fs_q       <= fs_d;
            lk_q       <= lk_d;
        end
    end

    assign vin.o_h_total     = out_q[4*P_CNT_W-1:3*P_CNT_W];
    assign vin.o_h_active    = out_q[3*P_CNT_W-1:2*P_CNT_W];
    assign vin.o_v_total     = out_q[2*P_CNT_W-1:P_CNT_W];
    assign vin.o_v_active    = out_q[P_CNT_W-1:0];
    assign vin.o_frame_start = fs_q;
    assign vin.o_locked      = lk_q;
endmodule

// File: tb/tb_fm_vin_timing_detect.sv
// Bench for fm_vin_timing_detect: frame table plus timeout
// and mid-frame reset sequences, checked at each frame start.
module tb_fm_vin_timing_detect;
    localparam int W = 12;

    logic clk_sys = 1'b0;
    logic rst_x   = 1'b1;

    fm_vin_timing_detect_if #(.P_CNT_W(W)) vif ();

    fm_vin_timing_detect #(
        .P_CNT_W      (W),
        .P_LOCK_FRAMES(2)
    ) dut (
        .clk_sys(clk_sys),
        .rst_x  (rst_x),
        .vin    (vif)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int ht;
        int ha;
        int vt;
        int va;
        bit lk;
    } exp_t;

    typedef struct {
        int   lines;
        int   act;
        int   de_len;
        bit   coinc;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   nfs    = 0;

    function automatic exp_t mk(int ht, int ha, int vt,
                                int va, bit lk);
        exp_t e;
        e.ht = ht;
        e.ha = ha;
        e.vt = vt;
        e.va = va;
        e.lk = lk;
        return e;
    endfunction

    function automatic vec_t vv(int lines, int act,
                                bit coinc, exp_t e);
        vec_t v;
        v.lines  = lines;
        v.act    = act;
        v.de_len = 16;
        v.coinc  = coinc;
        v.e      = e;
        return v;
    endfunction

    task automatic cmp(string nm, exp_t e);
        checks++;
        if (vif.o_h_total  !== W'(e.ht) ||
            vif.o_h_active !== W'(e.ha) ||
            vif.o_v_total  !== W'(e.vt) ||
            vif.o_v_active !== W'(e.va) ||
            vif.o_locked   !== e.lk) begin
            errors++;
            $display("FAIL %s: got %0d/%0d/%0d/%0d lock=%0b, want %0d/%0d/%0d/%0d lock=%0b",
                     nm, vif.o_h_total, vif.o_h_active,
                     vif.o_v_total, vif.o_v_active,
                     vif.o_locked, e.ht, e.ha, e.vt,
                     e.va, e.lk);
        end
    endtask

    always @(negedge clk_sys) begin
        if (vif.o_frame_start === 1'b1) begin
            nfs++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fs: pulse %0d, want none",
                         nfs);
            end else begin
                mon_e = sb.pop_front();
                cmp($sformatf("frame_start_%0d", nfs), mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_frame(vec_t v, int rst_line);
        int vc;
        vc = v.coinc ? 0 : 5;
        for (int l = 0; l < v.lines; l++) begin
            for (int c = 0; c < 20; c++) begin
                tick();
                if (l == rst_line && c == 11) begin
                    rst_x = 1'b0;
                    cmp("reset_mid_frame", mk(0, 0, 0, 0, 0));
                    checks++;
                    if (vif.o_frame_start !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_fs: got %0b, want 0",
                                 vif.o_frame_start);
                    end
                end
                if (l == rst_line && c == 10)
                    rst_x = 1'b1;
                if (l == 0 && c == vc)
                    sb.push_back(v.e);
                vif.i_hsync = (c < 2);
                vif.i_vsync = (l == 0) && (c >= vc);
                vif.i_de    = (l < v.act) && (c >= 3) &&
                              (c < 3 + v.de_len);
            end
        end
    endtask

    initial begin
        tbl.push_back(vv(10, 8, 0, mk( 0,  0,  0, 0, 0)));
        tbl.push_back(vv(10, 8, 0, mk(20, 16, 10, 8, 0)));
        tbl.push_back(vv(10, 8, 0, mk(20, 16, 10, 8, 0)));
        tbl.push_back(vv(11, 8, 0, mk(20, 16, 10, 8, 1)));
        tbl.push_back(vv(11, 8, 0, mk(20, 16, 11, 8, 0)));
        tbl.push_back(vv(11, 8, 0, mk(20, 16, 11, 8, 0)));
        tbl.push_back(vv(10, 0, 0, mk(20, 16, 11, 8, 1)));
        tbl.push_back(vv(10, 0, 0, mk(20,  0, 10, 0, 0)));
        tbl.push_back(vv(10, 0, 0, mk(20,  0, 10, 0, 0)));
        tbl.push_back(vv(10, 8, 1, mk(20,  0, 10, 0, 1)));
        tbl.push_back(vv(10, 8, 1, mk(20, 16, 10, 8, 0)));
        tbl.push_back(vv(10, 8, 1, mk(20, 16, 10, 8, 0)));
        tbl.push_back(vv(10, 8, 1, mk(20, 16, 10, 8, 1)));

        vif.i_hsync = 1'b0;
        vif.i_vsync = 1'b0;
        vif.i_de    = 1'b0;
        rst_x       = 1'b1;
        repeat (3) tick();
        cmp("reset_state", mk(0, 0, 0, 0, 0));
        rst_x = 1'b0;
        repeat (5) tick();

        foreach (tbl[i])
            send_frame(tbl[i], -1);

        // Line-rate hsync with no vsync until the line counter saturates.
        for (int k = 1; k <= 4100; k++) begin
            tick();
            vif.i_hsync = 1'b1;
            tick();
            vif.i_hsync = 1'b0;
            if (k == 4000)
                cmp("pre_timeout", mk(20, 16, 10, 8, 1));
        end
        repeat (10) tick();
        cmp("timeout", mk(20, 16, 10, 8, 0));

        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 1)), -1);

        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 1)), 5);
        send_frame(vv(10, 8, 0, mk( 0,  0,  0, 0, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 0)), -1);
        send_frame(vv(10, 8, 0, mk(20, 16, 10, 8, 1)), -1);

        repeat (30) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_fs: got %0d pending, want 0",
                     sb.size());
        end

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule

// File: doc/fm_vin_timing_detect.md
FM_VIN_TIMING_DETECT -- requirements
Module: fm_vin_timing_detect

Interface
REQ-001 Parameter P_CNT_W, default 12: width of all timing counters and measurement outputs.
REQ-002 Parameter P_LOCK_FRAMES, default 2: number of consecutive matching frames required for lock (legal range 1..15).
REQ-003 clk_sys  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_x  input  1  synchronous, active-high reset.
REQ-005 i_hsync  input  1  incoming horizontal sync, active-high.
REQ-006 i_vsync  input  1  incoming vertical sync, active-high.
REQ-007 i_de  input  1  incoming data enable, active-high.
REQ-008 o_h_total  output  P_CNT_W  clocks per line, last locked-candidate frame.
REQ-009 o_h_active  output  P_CNT_W  DE clocks per line.
REQ-010 o_v_total  output  P_CNT_W  lines per frame.
REQ-011 o_v_active  output  P_CNT_W  lines containing at least one DE clock.
REQ-012 o_frame_start  output  1  one-cycle pulse per detected vsync rising edge.
REQ-013 o_locked  output  1  timing stable for P_LOCK_FRAMES consecutive frames.

Function
REQ-014 i_hsync, i_vsync and i_de SHALL each be registered once, then compared with a second register for edge detection; a rising edge is flagged 2 cycles after it appears at the input.
REQ-015 Horizontal counter: cleared to 1 on a flagged hsync rise, else incremented, saturating at all-ones.
REQ-016 DE counter: cleared on hsync rise (loaded with 1 if registered DE is high that cycle), else incremented while registered DE is high, saturating.
REQ-017 On each hsync rise, the line length (horizontal counter value before clearing) and DE count SHALL be captured as the line result; the line counter increments, and the active-line counter increments if the ending line's DE count is non-zero.
REQ-018 Line and active-line counters SHALL saturate at all-ones and clear on a flagged vsync rise.
REQ-019 Simultaneous hsync and vsync rise: the line-end update of REQ-017 SHALL be applied first, and the frame capture of REQ-020 SHALL include that line.
REQ-020 On a flagged vsync rise, the frame tuple {h_total = last line length, h_active = largest non-zero line DE count in the frame, v_total, v_active} SHALL be formed and o_frame_start pulses that cycle.
REQ-021 States: SEARCH, TRACK, LOCKED; a 4-bit match counter.
REQ-022 SEARCH: on first vsync rise, go TRACK, match counter 0; frame tuple stored as reference; outputs not updated.
REQ-023 TRACK: on vsync rise, if tuple equals reference and no counter saturated during the frame, match counter increments; otherwise match counter clears; reference and outputs take the new tuple in both cases.
REQ-024 TRACK -> LOCKED when match counter reaches P_LOCK_FRAMES; o_locked rises in the same cycle as that frame's o_frame_start.
REQ-025 LOCKED: matching frame keeps state; mismatching or saturated frame -> TRACK, match counter 0, o_locked low in that same cycle, outputs take new tuple.
REQ-026 Timeout: if the line counter saturates (no vsync), any state -> SEARCH, o_locked low next cycle; measurement outputs hold their last values.
REQ-027 Input glitches shorter than one clock that are not sampled SHALL have no effect; no other filtering is performed.

Reset
REQ-028 While rst_x is high at a clock edge: state SEARCH, all counters, sample registers, match counter, reference and every output (o_h_total, o_h_active, o_v_total, o_v_active, o_frame_start, o_locked) SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release, the block behaves as after power-up (first vsync rise only enters TRACK).

Verification
REQ-030 Frame 20 clocks/line, DE 16 clocks, 10 lines, 8 active lines, P_LOCK_FRAMES=2 -> outputs 20/16/10/8 after 2nd vsync; o_locked rises with 4th o_frame_start.
REQ-031 Locked, then one frame with 11 lines -> o_locked low on that frame's o_frame_start, o_v_total=11; re-locks after 2 more matching 11-line frames.
REQ-032 hsync and vsync rising on same cycle in every frame -> v_total counts the coincident line; lock still achieved as REQ-030.
REQ-033 Locked, then vsync held low for >4095 lines (P_CNT_W=12) -> o_locked low, state SEARCH, outputs hold 20/16/10/8.
REQ-034 rst_x pulsed high for 1 cycle mid-frame while locked -> all outputs 0 next cycle; lock regained only at 4th vsync rise after release.
REQ-035 Frame with DE never asserted -> o_h_active=0, o_v_active=0; lock behaviour otherwise per REQ-030.
